spi_cfg_sequencer: RTL and testbench
====================================

SPI_CFG_SEQUENCER -- requirements
Module: spi_cfg_sequencer

Interface
REQ-001 Parameter N_REGS, 64, number of configuration table entries (power of two, 2..256).
REQ-002 Parameter AW, 6, table address width = log2(N_REGS).
REQ-003 Parameter GAP_CYC, 16, idle clk cycles between consecutive SPI writes (min 2).
REQ-004 Parameter TO_CYC, 4096, max clk cycles to wait for write completion before abort.
REQ-005 Port clk  in  1  single system clock; all logic on rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port cfg_start  in  1  start request, sampled in IDLE only.
REQ-008 Port tbl_addr  out  AW  synchronous-ROM read address.
REQ-009 Port tbl_data  in  24  ROM word (1rw+2ww+13a+8d), valid exactly 1 cycle after tbl_addr.
REQ-010 Port write_data  out  24  word handed to the downstream SPI writer.
REQ-011 Port write_data_valid  out  1  level request to the SPI writer; its rising edge launches a write.
REQ-012 Port once_end_w  in  1  1-cycle pulse from the SPI writer: write finished.
REQ-013 Port cfg_busy  out  1  high in every state except IDLE.
REQ-014 Port cfg_done  out  1  1-cycle pulse at end of a sequence (normal or aborted).
REQ-015 Port cfg_err  out  1  sticky timeout flag.
REQ-016 Port err_index  out  AW  table index of the write that timed out.

Function
REQ-017 States SHALL be IDLE, FETCH, LATCH, ISSUE, GAP, DONE.
REQ-018 IDLE: cfg_start=1 -> FETCH next cycle; idx<=0; cfg_err<=0; err_index<=0.
REQ-019 tbl_addr SHALL equal idx at all times.
REQ-020 FETCH: exactly 1 cycle -> LATCH.
REQ-021 LATCH: write_data<=tbl_data; tbl_data==24'hFFFFFF (end marker) -> DONE with no write issued; else -> ISSUE.
REQ-022 ISSUE: write_data_valid=1 for the whole state; write_data SHALL be stable while valid is high; timeout counter starts at 0 on entry and increments every cycle.
REQ-023 ISSUE + once_end_w=1: valid<=0; idx==N_REGS-1 -> DONE, else idx<=idx+1 and -> GAP.
REQ-024 ISSUE, counter reaches TO_CYC-1 without once_end_w: valid<=0, cfg_err<=1, err_index<=idx, -> DONE (sequence aborted).
REQ-025 once_end_w and timeout in the same cycle: once_end_w wins, no error.
REQ-026 GAP: valid stays 0 for exactly GAP_CYC cycles, then -> FETCH; guarantees a fresh rising edge of write_data_valid per write.
REQ-027 DONE: cfg_done=1 for exactly that cycle -> IDLE.
REQ-028 cfg_start outside IDLE SHALL be ignored (no restart, no queuing).
REQ-029 once_end_w outside ISSUE SHALL be ignored.
REQ-030 Latency cfg_start -> first write_data_valid rise: 3 cycles (FETCH, LATCH, ISSUE register).
REQ-031 Full table, no marker: exactly N_REGS writes, idx does not wrap past N_REGS-1.
REQ-032 cfg_err, err_index SHALL hold until the next accepted cfg_start.

Reset
REQ-033 rst_n=0 at any time, mid-write included: state=IDLE, idx=0, tbl_addr=0, write_data=0, write_data_valid=0, cfg_busy=0, cfg_done=0, cfg_err=0, err_index=0, counters=0, asynchronously.
REQ-034 After reset release, no write SHALL start until a new cfg_start.

Verification
REQ-035 Table {0x000A55, 0x0001AA, 0xFFFFFF}; start; SPI model acks after 50 cycles -> 2 writes with write_data 0x000A55 then 0x0001AA, one cfg_done, cfg_err=0.
REQ-036 N_REGS=4, no marker -> 4 writes, addresses 0..3, cfg_done after 4th once_end_w, valid low ≥GAP_CYC cycles between writes.
REQ-037 TO_CYC=100, model never acks entry 2 -> valid drops 100 cycles after its rise, cfg_err=1, err_index=2, cfg_done pulse, no further writes.
REQ-038 once_end_w coincident with final timeout cycle -> no error, sequence continues.
REQ-039 cfg_start pulsed during ISSUE and spurious once_end_w during GAP -> no effect on sequence or write count.
REQ-040 rst_n low during ISSUE of entry 1 -> all outputs zero immediately; new cfg_start restarts from address 0.

Source files
------------

// File: rtl/spi_cfg_sequencer.sv
// rtl/spi_cfg_sequencer.sv - walks a configuration ROM and hands each word to an SPI writer
// Stops on the 0xFFFFFF end marker, after the last table entry, or on a write timeout.
module spi_cfg_sequencer #(
  parameter int N_REGS  = 64,
  parameter int AW      = 6,
  parameter int GAP_CYC = 16,
  parameter int TO_CYC  = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  output logic [AW-1:0] tbl_addr,
  input  logic [23:0]   tbl_data,
  output logic [23:0]   write_data,
  output logic          write_data_valid,
  input  logic          once_end_w,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [AW-1:0] err_index
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // One counter serves both the write timeout and the inter-write gap.
  localparam int MAXC = (TO_CYC > GAP_CYC) ? TO_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_REGS - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
  localparam logic [23:0]   END_MARK = 24'hFFFFFF;

  logic [2:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [23:0]   r_wdata;
  logic          r_valid;
  logic          r_err;
  logic [AW-1:0] r_err_idx;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state   <= S_FETCH;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
          end
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_wdata <= tbl_data;
          if (tbl_data == END_MARK) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_ISSUE;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          // A completion in the final timeout cycle still counts as success.
          if (once_end_w) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= S_GAP;
            end
          end else if (r_cnt == TO_LAST) begin
            r_valid   <= 1'b0;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tbl_addr         = r_idx;
  assign write_data       = r_wdata;
  assign write_data_valid = r_valid;
  assign cfg_busy         = (r_state != S_IDLE);
  assign cfg_done         = (r_state == S_DONE);
  assign cfg_err          = r_err;
  assign err_index        = r_err_idx;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// tb/tb_spi_cfg_sequencer.sv - directed bench for spi_cfg_sequencer with ROM and SPI writer models
module tb_spi_cfg_sequencer;

  localparam int N_REGS  = 4;
  localparam int AW      = 2;
  localparam int GAP_CYC = 16;
  localparam int TO_CYC  = 100;
  localparam int GAP_EXP = GAP_CYC + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] tbl_addr;
  logic [23:0]   tbl_data;
  logic [23:0]   write_data;
  logic          write_data_valid;
  logic          once_end_w;
  logic          cfg_busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [AW-1:0] err_index;

  always #5 clk = ~clk;

  spi_cfg_sequencer #(
    .N_REGS(N_REGS), .AW(AW), .GAP_CYC(GAP_CYC), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .write_data(write_data), .write_data_valid(write_data_valid),
    .once_end_w(once_end_w), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_err(cfg_err), .err_index(err_index)
  );

  logic [23:0] rom [4];
  int          ack_dly [4];

  always @(posedge clk) tbl_data <= rom[tbl_addr];

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt, done_cnt, stab_err;
  logic [23:0] wr_data [8];
  logic [1:0]  wr_addr [8];
  int          hi_len [8];
  int          gap_len [8];
  bit          spur;
  int          ack_timer, hi_run, low_cnt;
  logic        prev_v;
  logic [23:0] prev_wd;

  // SPI writer model: logs each valid rise, acks ack_dly[addr] cycles later (0 = never)
  initial begin
    once_end_w = 1'b0; spur = 0; ack_timer = 0; hi_run = 0; low_cnt = 0;
    prev_v = 1'b0; prev_wd = '0; wr_cnt = 0; done_cnt = 0; stab_err = 0;
    forever begin
      @(negedge clk);
      once_end_w = spur;
      spur = 0;
      if (!rst_n) begin
        once_end_w = 1'b0; ack_timer = 0; prev_v = 1'b0; hi_run = 0; low_cnt = 0;
      end else begin
        if (cfg_done) done_cnt++;
        if (write_data_valid && prev_v && write_data !== prev_wd) stab_err++;
        if (write_data_valid && !prev_v) begin
          if (wr_cnt < 8) begin
            wr_data[wr_cnt] = write_data;
            wr_addr[wr_cnt] = tbl_addr;
            gap_len[wr_cnt] = low_cnt;
          end
          wr_cnt++;
          hi_run = 0;
          low_cnt = 0;
          ack_timer = ack_dly[tbl_addr];
        end
        if (write_data_valid) begin
          hi_run++;
          if (wr_cnt >= 1 && wr_cnt <= 8) hi_len[wr_cnt-1] = hi_run;
        end else begin
          low_cnt++;
        end
        if (ack_timer > 0) begin
          ack_timer--;
          if (ack_timer == 0) once_end_w = 1'b1;
        end
        prev_v = write_data_valid;
        prev_wd = write_data;
      end
    end
  end

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; stab_err = 0;
    for (int i = 0; i < 8; i++) begin
      hi_len[i] = 0; gap_len[i] = 0; wr_data[i] = '0; wr_addr[i] = '0;
    end
  endtask

  task automatic start_seq();
    @(negedge clk) cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cfg_done) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tbl_addr, write_data, write_data_valid, cfg_busy, cfg_done, cfg_err, err_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%0h wd=%0h v=%0b busy=%0b done=%0b err=%0b ei=%0h required all 0",
               tbl_addr, write_data, write_data_valid, cfg_busy, cfg_done, cfg_err, err_index);
    end
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    checks++;
    if (wr_cnt !== 0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_autostart: got writes=%0d busy=%0b required 0 0", wr_cnt, cfg_busy);
    end
  endtask

  task automatic test_marker_table();
    bit ok;
    rom[0] = 24'h000A55; rom[1] = 24'h0001AA; rom[2] = 24'hFFFFFF; rom[3] = 24'h123456;
    for (int i = 0; i < 4; i++) ack_dly[i] = 50;
    clear_log();
    start_seq();
    checks++;
    if (cfg_busy !== 1'b1 || write_data_valid !== 1'b0 || tbl_addr !== 2'd0) begin
      errors++;
      $display("FAIL fetch_state: got busy=%0b v=%0b addr=%0d required 1 0 0", cfg_busy, write_data_valid, tbl_addr);
    end
    @(negedge clk);
    checks++;
    if (write_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL latch_valid: got %0b required 0", write_data_valid);
    end
    @(negedge clk);
    checks++;
    if (write_data_valid !== 1'b1 || write_data !== 24'h000A55) begin
      errors++;
      $display("FAIL latency3: got v=%0b wd=%0h required 1 000a55", write_data_valid, write_data);
    end
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL marker_done_timeout: got no cfg_done required cfg_done"); end
    checks++;
    if (wr_cnt !== 2 || wr_data[0] !== 24'h000A55 || wr_data[1] !== 24'h0001AA) begin
      errors++;
      $display("FAIL marker_writes: got n=%0d d0=%0h d1=%0h required 2 000a55 0001aa", wr_cnt, wr_data[0], wr_data[1]);
    end
    checks++;
    if (done_cnt !== 1 || cfg_err !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL marker_status: got done=%0d err=%0b busy=%0b required 1 0 0", done_cnt, cfg_err, cfg_busy);
    end
  endtask

  task automatic test_full_table();
    bit ok;
    rom[0] = 24'h100111; rom[1] = 24'h200222; rom[2] = 24'h300333; rom[3] = 24'h400444;
    for (int i = 0; i < 4; i++) ack_dly[i] = 10;
    clear_log();
    start_seq();
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_done_timeout: got no cfg_done required cfg_done"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr[i] !== 2'(i) || wr_data[i] !== rom[i] || hi_len[i] !== 10) begin
        errors++;
        $display("FAIL full_write%0d: got addr=%0d data=%0h hi=%0d required %0d %0h 10",
                 i, wr_addr[i], wr_data[i], hi_len[i], i, rom[i]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (gap_len[i] !== GAP_EXP) begin
        errors++;
        $display("FAIL full_gap%0d: got %0d low cycles required %0d", i, gap_len[i], GAP_EXP);
      end
    end
    repeat (60) @(negedge clk);
    checks++;
    if (wr_cnt !== 4 || done_cnt !== 1 || stab_err !== 0) begin
      errors++;
      $display("FAIL full_count: got writes=%0d done=%0d unstable=%0d required 4 1 0", wr_cnt, done_cnt, stab_err);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    rom[0] = 24'h000010; rom[1] = 24'h000020; rom[2] = 24'h000030; rom[3] = 24'h000040;
    ack_dly[0] = 5; ack_dly[1] = 5; ack_dly[2] = 0; ack_dly[3] = 5;
    clear_log();
    start_seq();
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_done_timeout: got no cfg_done required cfg_done"); end
    checks++;
    if (hi_len[2] !== TO_CYC) begin
      errors++;
      $display("FAIL to_valid_len: got %0d required %0d", hi_len[2], TO_CYC);
    end
    checks++;
    if (cfg_err !== 1'b1 || err_index !== 2'd2) begin
      errors++;
      $display("FAIL to_err: got err=%0b idx=%0d required 1 2", cfg_err, err_index);
    end
    repeat (150) @(negedge clk);
    checks++;
    if (wr_cnt !== 3 || done_cnt !== 1 || cfg_err !== 1'b1 || err_index !== 2'd2) begin
      errors++;
      $display("FAIL to_hold: got writes=%0d done=%0d err=%0b idx=%0d required 3 1 1 2",
               wr_cnt, done_cnt, cfg_err, err_index);
    end
  endtask

  task automatic test_coincident();
    bit ok;
    ack_dly[0] = 5; ack_dly[1] = TO_CYC; ack_dly[2] = 5; ack_dly[3] = 5;
    clear_log();
    start_seq();
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL coin_done_timeout: got no cfg_done required cfg_done"); end
    checks++;
    if (wr_cnt !== 4 || cfg_err !== 1'b0 || hi_len[1] !== TO_CYC) begin
      errors++;
      $display("FAIL coincident: got writes=%0d err=%0b hi1=%0d required 4 0 %0d",
               wr_cnt, cfg_err, hi_len[1], TO_CYC);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    bit seen;
    for (int i = 0; i < 4; i++) ack_dly[i] = 20;
    clear_log();
    start_seq();
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (write_data_valid) seen = 1;
    end
    cfg_start = 1'b1;
    @(negedge clk) cfg_start = 1'b0;
    for (int i = 0; i < 200 && !(wr_cnt == 1 && !write_data_valid); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    spur = 1;
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || !seen) begin errors++; $display("FAIL ign_done_timeout: got done=%0b issue=%0b required 1 1", ok, seen); end
    checks++;
    if (wr_cnt !== 4 || done_cnt !== 1 || gap_len[1] !== GAP_EXP || wr_addr[1] !== 2'd1) begin
      errors++;
      $display("FAIL ignored: got writes=%0d done=%0d gap1=%0d addr1=%0d required 4 1 %0d 1",
               wr_cnt, done_cnt, gap_len[1], wr_addr[1], GAP_EXP);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bit seen;
    for (int i = 0; i < 4; i++) ack_dly[i] = 30;
    clear_log();
    start_seq();
    seen = 0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (write_data_valid && tbl_addr == 2'd1) seen = 1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!seen || {tbl_addr, write_data, write_data_valid, cfg_busy, cfg_done, cfg_err, err_index} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got issue=%0b addr=%0h wd=%0h v=%0b busy=%0b required 1 and all 0",
               seen, tbl_addr, write_data, write_data_valid, cfg_busy);
    end
    @(negedge clk) rst_n = 1'b1;
    clear_log();
    repeat (40) @(negedge clk);
    checks++;
    if (wr_cnt !== 0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got writes=%0d busy=%0b required 0 0", wr_cnt, cfg_busy);
    end
    start_seq();
    wait_done(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || wr_cnt !== 4 || wr_addr[0] !== 2'd0 || wr_data[0] !== rom[0]) begin
      errors++;
      $display("FAIL restart: got done=%0b writes=%0d addr0=%0d d0=%0h required 1 4 0 %0h",
               ok, wr_cnt, wr_addr[0], wr_data[0], rom[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin rom[i] = '0; ack_dly[i] = 0; end
    test_reset();
    test_marker_table();
    test_full_table();
    test_timeout();
    test_coincident();
    test_ignored_inputs();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
